// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer and flush-to-bubble
// Optional saturating statistics counters: PIPE_STAGE_SKID_STATS_EN
module pipe_stage_skid #(
   parameter int               WIDTH      = 64,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
   parameter int               CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_drops
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             acc;
   logic             take;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;

   assign acc  = in_valid & in_ready;
   assign take = out_valid & out_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= EMPTY;
         main_q <= BUBBLE_VAL;
         skid_q <= BUBBLE_VAL;
      end else if (flush) begin
         state  <= EMPTY;
         main_q <= BUBBLE_VAL;
         skid_q <= BUBBLE_VAL;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state  <= BUSY;
                  main_q <= in_data;
               end
            end
            BUSY: begin
               if (acc && take) begin
                  main_q <= in_data;
               end else if (acc) begin
                  state  <= FULL;
                  skid_q <= in_data;
               end else if (take) begin
                  state  <= EMPTY;
                  main_q <= BUBBLE_VAL;
               end
            end
            FULL: begin
               if (take) begin
                  state  <= BUSY;
                  main_q <= skid_q;
                  skid_q <= BUBBLE_VAL;
               end
            end
            default: begin
               state  <= EMPTY;
               main_q <= BUBBLE_VAL;
               skid_q <= BUBBLE_VAL;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_SKID_STATS_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] drops_q;
   logic [1:0]       drop_n;
   logic [CNT_W+1:0] drop_sum;

   // A take in the flush cycle still delivers the head; an acc is lost with the rest.
   always_comb begin
      drop_n   = occupancy - {1'b0, take} + {1'b0, acc};
      drop_sum = {2'b00, drops_q} + {{CNT_W{1'b0}}, drop_n};
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
         drops_q <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);
         if (flush)
            drops_q <= (drop_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end
   end

   assign stall_cycles = stall_q;
   assign flush_drops  = drops_q;
`else
   assign stall_cycles = '0;
   assign flush_drops  = '0;
`endif

endmodule
